// File: rtl/mem_bus_fabric_pkg.sv
// Memory bus fabric shared definitions: FSM states and default memory map.
// Slave order 0..3 is ROM, RAM, UART, OUT_PORT.
package mem_bus_fabric_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [31:0] ROM_BASE      = 32'h0000_0000;
  localparam logic [31:0] ROM_SIZE      = 32'h0000_1000;
  localparam logic [31:0] RAM_BASE      = 32'h0000_1000;
  localparam logic [31:0] RAM_SIZE      = 32'h0000_1000;
  localparam logic [31:0] UART_BASE     = 32'h0000_2000;
  localparam logic [31:0] UART_SIZE     = 32'h0000_0004;
  localparam logic [31:0] OUT_PORT_BASE = 32'h0000_3000;
  localparam logic [31:0] OUT_PORT_SIZE = 32'h0000_0004;

  localparam logic [127:0] DEF_SLAVE_BASE =
    {OUT_PORT_BASE, UART_BASE, RAM_BASE, ROM_BASE};
  localparam logic [127:0] DEF_SLAVE_SIZE =
    {OUT_PORT_SIZE, UART_SIZE, RAM_SIZE, ROM_SIZE};

endpackage

// File: rtl/mem_bus_fabric_decoder.sv
// Address window decoder: one-hot hit vector plus offset into the window.
// Lowest index wins on overlap; a zero-size window can never match.
module addr_window_decoder #(
  parameter int                         NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*32-1:0]   SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*32-1:0]   SLAVE_SIZE = '0
) (
  input  logic [31:0]           addr,
  output logic [NUM_SLAVES-1:0] hit,
  output logic [31:0]           offset
);

  logic [32:0] lo;
  logic [32:0] hi;

  always_comb begin
    hit    = '0;
    offset = '0;
    lo     = '0;
    hi     = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      lo = {1'b0, SLAVE_BASE[i*32 +: 32]};
      hi = lo + {1'b0, SLAVE_SIZE[i*32 +: 32]};
      if ({1'b0, addr} >= lo && {1'b0, addr} < hi) begin
        hit    = '0;
        hit[i] = 1'b1;
        offset = addr - lo[31:0];
      end
    end
  end

endmodule

// File: rtl/mem_bus_fabric.sv
// Single-master memory bus fabric: IDLE -> WAIT -> RESP transfer FSM.
// Optional WAIT timeout is built in with `define BUS_TIMEOUT_EN.
module mem_bus_fabric
  import mem_bus_fabric_pkg::*;
#(
  parameter int                       NUM_SLAVES     = 4,
  parameter int                       DATA_W         = 8,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE     = DEF_SLAVE_BASE,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_SIZE     = DEF_SLAVE_SIZE,
  parameter int                       TIMEOUT_CYCLES = 15
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         m_req,
  input  logic                         m_we,
  input  logic [31:0]                  m_addr,
  input  logic [DATA_W-1:0]            m_wdata,
  output logic [DATA_W-1:0]            m_rdata,
  output logic                         m_ready,
  output logic                         m_err,
  output logic [NUM_SLAVES-1:0]        s_sel,
  output logic [31:0]                  s_addr,
  output logic                         s_we,
  output logic [DATA_W-1:0]            s_wdata,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]        s_ready
);

  state_t                state;
  logic                  we_q;
  logic [NUM_SLAVES-1:0] hit;
  logic [31:0]           offset;
  logic                  sel_rdy;
  logic [DATA_W-1:0]     sel_rdata;
  logic                  tmo;

  addr_window_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_SIZE (SLAVE_SIZE)
  ) u_dec (
    .addr   (m_addr),
    .hit    (hit),
    .offset (offset)
  );

  // s_sel is one-hot, so OR-ing the gated lanes is a mux
  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (s_sel[i]) sel_rdata |= s_rdata[i*DATA_W +: DATA_W];
    end
  end

  assign sel_rdy = |(s_ready & s_sel);

`ifdef BUS_TIMEOUT_EN
  logic [7:0] wait_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (state == ST_WAIT) begin
      wait_cnt <= wait_cnt + 8'd1;
    end else begin
      wait_cnt <= '0;
    end
  end

  assign tmo = (wait_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      we_q    <= 1'b0;
      s_sel   <= '0;
      s_we    <= 1'b0;
      s_addr  <= '0;
      s_wdata <= '0;
      m_ready <= 1'b0;
      m_err   <= 1'b0;
      m_rdata <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          m_ready <= 1'b0;
          m_err   <= 1'b0;
          m_rdata <= '0;
          if (m_req) begin
            we_q    <= m_we;
            s_addr  <= offset;
            s_wdata <= m_wdata;
            if (|hit) begin
              s_sel <= hit;
              s_we  <= m_we;
              state <= ST_WAIT;
            end else begin
              m_ready <= 1'b1;
              m_err   <= 1'b1;
              state   <= ST_RESP;
            end
          end
        end
        ST_WAIT: begin
          if (sel_rdy) begin
            s_sel   <= '0;
            s_we    <= 1'b0;
            m_ready <= 1'b1;
            m_rdata <= we_q ? '0 : sel_rdata;
            state   <= ST_RESP;
          end else if (tmo) begin
            s_sel   <= '0;
            s_we    <= 1'b0;
            m_ready <= 1'b1;
            m_err   <= 1'b1;
            m_rdata <= '0;
            state   <= ST_RESP;
          end
        end
        ST_RESP: begin
          m_ready <= 1'b0;
          m_err   <= 1'b0;
          m_rdata <= '0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
